// File: rtl/instr_imm_encoder_if.sv
// Request/response bundle for instr_imm_encoder: decoded fields in, packed word and address out.
// Both sides use valid/ready; the master is the request producer and output sink.
interface instr_imm_encoder_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [63:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] addr;

   modport master (
      output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
      input  in_ready, out_valid, instr, addr
   );

   modport slave (
      input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
      output in_ready, out_valid, instr, addr
   );
endinterface

// File: rtl/instr_imm_encoder.sv
// Packs decoded fields plus a 64-bit immediate into one 32-bit word with a sequential address.
// Latency 1 cycle, one word per cycle; in_ready = empty || out_ready, out-of-range immediates dropped and counted.
module instr_imm_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_imm_encoder_if.slave     bus,
   input  logic                   clear,
   output logic [7:0]             err_count
);

   typedef enum logic {EMPTY, FULL} state_t;
   typedef enum logic [2:0] {F_R, F_IU, F_IS, F_S, F_SB, F_U, F_UJ} fmt_t;

   state_t            state;
   fmt_t              fmt;
   logic              legal;
   logic [31:0]       word;
   logic              accept;
   logic              acc_ok;
   logic              acc_drop;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] cap_addr;
   logic              out_valid_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        err_q;

   always_comb begin
      fmt = F_R;
      case (bus.opcode)
         7'd3:    fmt = F_IU;
         7'd103:  fmt = (bus.funct3 == 3'd0) ? F_IU : F_SB;
         7'd19:   fmt = (bus.funct3 == 3'd0 || bus.funct3 == 3'd2) ? F_IS : F_R;
         7'd35:   fmt = F_S;
         7'd99:   fmt = F_SB;
         7'd55:   fmt = F_U;
         7'd111:  fmt = F_UJ;
         default: fmt = F_R;
      endcase
   end

   // Range checks work on the raw two's-complement bits: upper bits must be pure sign/zero extension.
   always_comb begin
      legal = 1'b1;
      word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      case (fmt)
         F_IU: begin
            legal = (bus.imm[63:12] == '0);
            word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         F_IS: begin
            legal = (&bus.imm[63:11]) || (~|bus.imm[63:11]);
            word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
         F_S: begin
            legal = (bus.imm[63:12] == '0);
            word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
         end
         F_SB: begin
            legal = (bus.imm[63:14] == '0) && (bus.imm[1:0] == 2'b00);
            word  = {bus.imm[13], bus.imm[11:6], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[5:2], bus.imm[12], bus.opcode};
         end
         F_U: begin
            legal = (bus.imm[63:32] == '0) && (bus.imm[11:0] == 12'd0);
            word  = {bus.imm[31:12], bus.rd, bus.opcode};
         end
         F_UJ: begin
            legal = (bus.imm[63:22] == '0) && (bus.imm[1:0] == 2'b00);
            word  = {bus.imm[21], bus.imm[11:2], bus.imm[12], bus.imm[20:13], bus.rd, bus.opcode};
         end
         default: begin
            legal = 1'b1;
            word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         end
      endcase
   end

   assign bus.in_ready = (state == EMPTY) || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign acc_ok       = accept && legal;
   assign acc_drop     = accept && !legal;
   assign cap_addr     = clear ? BASE_ADDR : wptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         addr_q      <= BASE_ADDR;
         wptr        <= BASE_ADDR;
         err_q       <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (acc_ok) begin
                  state       <= FULL;
                  out_valid_q <= 1'b1;
                  instr_q     <= word;
                  addr_q      <= cap_addr;
               end
            end
            FULL: begin
               // A legal accept here implies out_ready, so the old word leaves as the new one lands.
               if (acc_ok) begin
                  instr_q <= word;
                  addr_q  <= cap_addr;
               end else if (bus.out_ready) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase

         if (clear)
            wptr <= acc_ok ? BASE_ADDR + ADDR_W'(4) : BASE_ADDR;
         else if (acc_ok)
            wptr <= wptr + ADDR_W'(4);

         if (clear)
            err_q <= '0;
         else if (acc_drop && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.instr     = instr_q;
   assign bus.addr      = addr_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Randomized and directed bench for instr_imm_encoder against an arithmetic reference model.
// Each cycle drives at negedge, predicts the registered result, and samples 1 time unit after posedge.
module tb_instr_imm_encoder;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0;
   localparam longint      P7  = 64'd128;
   localparam longint      P12 = 64'd4096;
   localparam longint      P15 = 64'd32768;
   localparam longint      P20 = 64'd1048576;
   localparam longint      P21 = 64'd2097152;
   localparam longint      P25 = 64'd33554432;
   localparam longint      P31 = 64'd2147483648;
   localparam longint      P32 = 64'd4294967296;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic [7:0] err_count;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_full;
   logic [31:0] m_instr;
   logic [31:0] m_addr;
   logic [31:0] m_wptr;
   int          m_err;

   always #5 clk = ~clk;

   instr_imm_encoder_if #(.ADDR_W(ADDR_W)) bus();

   instr_imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .clear     (clear),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Encoding rules stated as numeric ranges and weighted bit-field sums.
   function automatic void ref_encode(input int op, input int f3, input int f7, input int rd_,
                                      input int rs1_, input int rs2_, input longint im,
                                      output bit legal, output logic [31:0] w);
      longint r;
      legal = 1'b1;
      if (op == 3 || (op == 103 && f3 == 0)) begin
         legal = (im >= 0) && (im < 4096);
         r = op + rd_ * P7 + f3 * P12 + rs1_ * P15 + (im & 4095) * P20;
      end else if (op == 19 && (f3 == 0 || f3 == 2)) begin
         legal = (im >= -2048) && (im <= 2047);
         r = op + rd_ * P7 + f3 * P12 + rs1_ * P15 + (im & 4095) * P20;
      end else if (op == 35) begin
         legal = (im >= 0) && (im < 4096);
         r = op + (im & 31) * P7 + f3 * P12 + rs1_ * P15 + rs2_ * P20 + ((im >> 5) & 127) * P25;
      end else if (op == 99 || op == 103) begin
         legal = (im >= 0) && (im < 16384) && ((im & 3) == 0);
         r = op + ((im >> 12) & 1) * P7 + ((im >> 2) & 15) * 256 + f3 * P12 + rs1_ * P15
             + rs2_ * P20 + ((im >> 6) & 63) * P25 + ((im >> 13) & 1) * P31;
      end else if (op == 55) begin
         legal = (im >= 0) && (im < P32) && ((im & 4095) == 0);
         r = op + rd_ * P7 + ((im >> 12) & 1048575) * P12;
      end else if (op == 111) begin
         legal = (im >= 0) && (im < 4194304) && ((im & 3) == 0);
         r = op + rd_ * P7 + ((im >> 13) & 255) * P12 + ((im >> 12) & 1) * P20
             + ((im >> 2) & 1023) * P21 + ((im >> 21) & 1) * P31;
      end else begin
         r = op + rd_ * P7 + f3 * P12 + rs1_ * P15 + rs2_ * P20 + f7 * P25;
      end
      w = r[31:0];
   endfunction

   task automatic cycle(input bit v, input int op, input int f3, input int f7, input int rd_,
                        input int rs1_, input int rs2_, input longint im, input bit ordy,
                        input bit clr);
      bit          legal;
      bit          acc;
      logic [31:0] w;
      @(negedge clk);
      bus.in_valid  = v;
      bus.opcode    = 7'(op);
      bus.funct3    = 3'(f3);
      bus.funct7    = 7'(f7);
      bus.rd        = 5'(rd_);
      bus.rs1       = 5'(rs1_);
      bus.rs2       = 5'(rs2_);
      bus.imm       = im;
      bus.out_ready = ordy;
      clear         = clr;
      #1;
      check("in_ready", 64'(bus.in_ready), 64'(!m_full || ordy));
      ref_encode(op, f3, f7, rd_, rs1_, rs2_, im, legal, w);
      acc = v && (!m_full || ordy);
      if (acc && legal) begin
         m_full  = 1'b1;
         m_instr = w;
         m_addr  = clr ? BASE : m_wptr;
      end else if (ordy) begin
         m_full = 1'b0;
      end
      if (clr) m_wptr = (acc && legal) ? BASE + 32'd4 : BASE;
      else if (acc && legal) m_wptr = m_wptr + 32'd4;
      if (clr) m_err = 0;
      else if (acc && !legal && m_err < 255) m_err++;
      @(posedge clk);
      #1;
      check("out_valid", 64'(bus.out_valid), 64'(m_full));
      if (m_full) begin
         check("instr", 64'(bus.instr), 64'(m_instr));
         check("addr", 64'(bus.addr), 64'(m_addr));
      end
      check("err_count", 64'(err_count), 64'(m_err));
   endtask

   task automatic idle(input bit ordy, input bit clr);
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, ordy, clr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int     ops[8];
      longint edges[8];
      int     op;
      longint im;
      ops   = '{3, 103, 19, 35, 99, 55, 111, 0};
      edges = '{2047, 2048, -2048, -2049, 4095, 4096, 16380, P32};

      reset = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
      bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0; bus.out_ready = 1'b0;
      m_full = 1'b0; m_instr = '0; m_addr = BASE; m_wptr = BASE; m_err = 0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_instr", 64'(bus.instr), 64'd0);
      check("rst_addr", 64'(bus.addr), 64'(BASE));
      check("rst_err", 64'(err_count), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      reset = 1'b0;

      // Dropped I-signed immediate, then a legal one still lands at the base address.
      cycle(1, 8'h13, 0, 0, 1, 0, 0, 2048, 1, 0);
      check("drop_isigned_valid", 64'(bus.out_valid), 64'd0);
      check("drop_isigned_err", 64'(err_count), 64'd1);
      cycle(1, 8'h13, 0, 0, 1, 0, 0, -1, 1, 0);
      check("isigned_instr", 64'(bus.instr), 64'hFFF00093);
      check("isigned_addr", 64'(bus.addr), 64'h0);
      idle(1, 1);

      cycle(1, 8'h37, 0, 0, 5, 0, 0, 64'h12345000, 1, 0);
      check("lui_instr", 64'(bus.instr), 64'h123452B7);
      cycle(1, 8'h37, 0, 0, 5, 0, 0, 64'h12345001, 1, 0);
      check("lui_drop_err", 64'(err_count), 64'd1);
      idle(1, 1);
      cycle(1, 8'h6F, 0, 0, 1, 0, 0, 8, 1, 0);
      check("jal_instr", 64'(bus.instr), 64'h004000EF);
      cycle(1, 8'h6F, 0, 0, 1, 0, 0, 6, 1, 0);
      check("jal_drop_err", 64'(err_count), 64'd1);

      // Backpressure: the first word is accepted alongside clear, the second waits out a 3-cycle stall.
      cycle(1, 8'h33, 1, 7'h20, 3, 4, 5, 0, 0, 1);
      check("bp_first_addr", 64'(bus.addr), 64'h0);
      repeat (3) begin
         cycle(1, 8'h13, 0, 0, 7, 2, 0, 100, 0, 0);
         check("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_stall_addr", 64'(bus.addr), 64'h0);
      end
      cycle(1, 8'h13, 0, 0, 7, 2, 0, 100, 1, 0);
      check("bp_second_addr", 64'(bus.addr), 64'h4);
      idle(1, 0);
      check("bp_drained", 64'(bus.out_valid), 64'd0);

      repeat (300) cycle(1, 55, 0, 0, 1, 0, 0, 1, 1, 0);
      check("sat_err", 64'(err_count), 64'd255);
      idle(1, 1);
      check("clear_err", 64'(err_count), 64'd0);

      repeat (3000) begin
         op = ops[$urandom_range(0, 7)];
         if (op == 0) op = $urandom_range(0, 127);
         case ($urandom_range(0, 7))
            0: im = $urandom_range(0, 4095);
            1: im = -longint'($urandom_range(0, 2100));
            2: im = $urandom_range(0, 16383);
            3: im = $urandom_range(0, 4194303);
            4: im = longint'({32'h0, $urandom() & 32'hFFFF_F000});
            5: im = longint'({$urandom(), $urandom()});
            6: im = edges[$urandom_range(0, 7)];
            default: im = longint'($urandom_range(0, 4095)) * 4;
         endcase
         cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 7), $urandom_range(0, 127),
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), im,
               $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      end

      // Asynchronous reset while a word is held under backpressure.
      cycle(1, 8'h33, 0, 0, 1, 2, 3, 0, 0, 0);
      cycle(1, 55, 0, 0, 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_err", 64'(err_count), 64'd0);
      m_full = 1'b0; m_wptr = BASE; m_err = 0;
      @(negedge clk);
      reset = 1'b0;
      cycle(1, 8'h33, 0, 0, 9, 1, 1, 0, 1, 0);
      check("arst_restart_addr", 64'(bus.addr), 64'(BASE));
      check("arst_restart_err", 64'(err_count), 64'd0);
      idle(1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
